// File: rtl/elink_trig_peak_reader.sv
// elink_trig_peak_reader: scans fixed-length trigger windows of a summed word
// stream and queues one record per window holding the first nonzero word
// (amplitude and sample index), plus a flag set when more nonzero words followed.
// The window is aligned by the sync strobe. Records go through a small FIFO with
// valid/ready handshake and a sticky overflow flag.
// Optional feature: define TRIG_READER_THRESH_EN to add the thresh port and
// suppress records whose amplitude is below it.
module elink_trig_peak_reader #(
    parameter int unsigned MULTISAMPLE = 8,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] data_in,
    input  logic        sync,
`ifdef TRIG_READER_THRESH_EN
    input  logic [12:0] thresh,
`endif
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [12:0] rec_amp,
    output logic [3:0]  rec_idx,
    output logic        rec_multi,
    output logic        overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [3:0]    LAST_IDX = 4'(MULTISAMPLE - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    // window search state
    logic [3:0]  cnt_q, cnt_d;
    logic        pk_valid_q, pk_valid_d;
    logic [12:0] pk_amp_q, pk_amp_d;
    logic [3:0]  pk_idx_q, pk_idx_d;
    logic        pk_multi_q, pk_multi_d;

    logic [3:0]  cur_idx;
    logic        thresh_ok;
    logic        push;
    logic [12:0] push_amp;
    logic [3:0]  push_idx;
    logic        push_multi;

    // record FIFO state
    logic [12:0]   amp_mem_q   [FIFO_DEPTH];
    logic [12:0]   amp_mem_d   [FIFO_DEPTH];
    logic [3:0]    idx_mem_q   [FIFO_DEPTH];
    logic [3:0]    idx_mem_d   [FIFO_DEPTH];
    logic          multi_mem_q [FIFO_DEPTH];
    logic          multi_mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic pop;
    logic full;
    logic do_push;

    // Window search: sync restarts the window on the current word, the first
    // nonzero word is latched, and the last sample emits the record and clears.
    always_comb begin
        cur_idx    = sync ? '0 : cnt_q;
        pk_valid_d = sync ? 1'b0 : pk_valid_q;
        pk_amp_d   = sync ? '0 : pk_amp_q;
        pk_idx_d   = sync ? '0 : pk_idx_q;
        pk_multi_d = sync ? 1'b0 : pk_multi_q;

        if (data_in != '0) begin
            if (!pk_valid_d) begin
                pk_valid_d = 1'b1;
                pk_amp_d   = data_in;
                pk_idx_d   = cur_idx;
                pk_multi_d = 1'b0;
            end else begin
                pk_multi_d = 1'b1;
            end
        end

`ifdef TRIG_READER_THRESH_EN
        thresh_ok = (pk_amp_d >= thresh);
`else
        thresh_ok = 1'b1;
`endif

        push       = 1'b0;
        push_amp   = pk_amp_d;
        push_idx   = pk_idx_d;
        push_multi = pk_multi_d;

        if (cur_idx == LAST_IDX) begin
            push       = pk_valid_d && thresh_ok;
            pk_valid_d = 1'b0;
            pk_amp_d   = '0;
            pk_idx_d   = '0;
            pk_multi_d = 1'b0;
            cnt_d      = '0;
        end else begin
            cnt_d = cur_idx + 4'd1;
        end
    end

    // FIFO control: a pop frees a slot in the same edge, so push+pop when full
    // succeeds; a push that finds no slot is dropped and flags overflow.
    always_comb begin
        pop     = (count_q != '0) && rec_ready;
        full    = (count_q == DEPTH_C);
        do_push = push && (!full || pop);

        amp_mem_d   = amp_mem_q;
        idx_mem_d   = idx_mem_q;
        multi_mem_d = multi_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (push && full && !pop);

        if (do_push) begin
            amp_mem_d[wr_ptr_q]   = push_amp;
            idx_mem_d[wr_ptr_q]   = push_idx;
            multi_mem_d[wr_ptr_q] = push_multi;
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            pk_valid_q <= 1'b0;
            pk_amp_q   <= '0;
            pk_idx_q   <= '0;
            pk_multi_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                amp_mem_q[i]   <= '0;
                idx_mem_q[i]   <= '0;
                multi_mem_q[i] <= 1'b0;
            end
        end else begin
            cnt_q       <= cnt_d;
            pk_valid_q  <= pk_valid_d;
            pk_amp_q    <= pk_amp_d;
            pk_idx_q    <= pk_idx_d;
            pk_multi_q  <= pk_multi_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            amp_mem_q   <= amp_mem_d;
            idx_mem_q   <= idx_mem_d;
            multi_mem_q <= multi_mem_d;
        end
    end

    // Head-of-FIFO outputs; forced to zero while empty so reset shows zeros.
    always_comb begin
        rec_valid = (count_q != '0);
        rec_amp   = rec_valid ? amp_mem_q[rd_ptr_q]   : '0;
        rec_idx   = rec_valid ? idx_mem_q[rd_ptr_q]   : '0;
        rec_multi = rec_valid ? multi_mem_q[rd_ptr_q] : 1'b0;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_elink_trig_peak_reader.sv
// Self-checking bench for elink_trig_peak_reader: directed scenarios plus
// randomized traffic against a window/queue reference model.
module tb_elink_trig_peak_reader;

    localparam int MS    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] data_in;
    logic        sync;
    logic [12:0] thresh;
    logic        rec_valid;
    logic        rec_ready;
    logic [12:0] rec_amp;
    logic [3:0]  rec_idx;
    logic        rec_multi;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [12:0] amp;
        logic [3:0]  idx;
        logic        multi;
    } rec_t;

    rec_t        exp_q[$];
    logic [12:0] win_q[$];
    logic        exp_ovf;
    logic [12:0] wv [MS];

    always #5 clk = ~clk;

    elink_trig_peak_reader #(
        .MULTISAMPLE(MS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .sync     (sync),
`ifdef TRIG_READER_THRESH_EN
        .thresh   (thresh),
`endif
        .rec_valid(rec_valid),
        .rec_ready(rec_ready),
        .rec_amp  (rec_amp),
        .rec_idx  (rec_idx),
        .rec_multi(rec_multi),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        win_q.delete();
        exp_ovf = 1'b0;
    endfunction

    // One clock edge of the reference: windows are collected as lists of words,
    // evaluated once they hold MS words, then the record queue is updated.
    function automatic void model_edge(input logic [12:0] d, input logic s, input logic r);
        rec_t nr;
        bit   have;
        bit   pop;
        int   nz;
        have   = 0;
        nz     = 0;
        nr.amp = '0;
        nr.idx = '0;
        pop    = (exp_q.size() != 0) && r;
        if (s) win_q.delete();
        win_q.push_back(d);
        if (win_q.size() == MS) begin
            for (int i = 0; i < MS; i++) begin
                if (win_q[i] != 0) begin
                    if (nz == 0) begin
                        nr.amp = win_q[i];
                        nr.idx = 4'(i);
                    end
                    nz++;
                end
            end
            nr.multi = (nz > 1);
            have     = (nz > 0);
`ifdef TRIG_READER_THRESH_EN
            if (have && nr.amp < thresh) have = 0;
`endif
            win_q.delete();
        end
        if (pop) void'(exp_q.pop_front());
        if (have) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(nr);
            else exp_ovf = 1'b1;
        end
    endfunction

    task automatic verify_outputs();
        check("rec_valid", rec_valid, exp_q.size() != 0);
        check("overflow", overflow, exp_ovf);
        if (exp_q.size() != 0) begin
            check("rec_amp", rec_amp, exp_q[0].amp);
            check("rec_idx", rec_idx, exp_q[0].idx);
            check("rec_multi", rec_multi, exp_q[0].multi);
        end
    endtask

    // Called at a negedge: drive one word, advance the model, sample at next negedge.
    task automatic step(input logic [12:0] d, input logic s, input logic r);
        data_in   = d;
        sync      = s;
        rec_ready = r;
        model_edge(d, s, r);
        @(posedge clk);
        @(negedge clk);
        verify_outputs();
    endtask

    task automatic run_win(input logic r);
        for (int i = 0; i < MS; i++) step(wv[i], 1'b0, r);
    endtask

    task automatic clear_wv();
        for (int i = 0; i < MS; i++) wv[i] = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        data_in   = '0;
        sync      = 1'b0;
        rec_ready = 1'b0;
        thresh    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", rec_valid, 0);
        check("reset_ovf", overflow, 0);
        check("reset_amp", rec_amp, 0);
        check("reset_idx", rec_idx, 0);
        check("reset_multi", rec_multi, 0);
        rst_n = 1'b1;

        // single peak at index 3
        clear_wv();
        wv[3] = 13'h123;
        run_win(1'b1);
        check("single_valid", rec_valid, 1);
        check("single_amp", rec_amp, 13'h123);
        check("single_idx", rec_idx, 3);
        check("single_multi", rec_multi, 0);

        // two peaks: first kept, multi set
        clear_wv();
        wv[1] = 13'h010;
        wv[4] = 13'h020;
        run_win(1'b1);
        check("multi_amp", rec_amp, 13'h010);
        check("multi_idx", rec_idx, 1);
        check("multi_flag", rec_multi, 1);

        // all-zero window
        clear_wv();
        run_win(1'b1);
        check("zero_win_valid", rec_valid, 0);

        // fill past depth with no reader
        for (int p = 1; p <= 6; p++) begin
            clear_wv();
            wv[0] = 13'(p);
            run_win(1'b0);
        end
        check("ovf_set", overflow, 1);
        for (int k = 1; k <= DEPTH; k++) begin
            check("drain_amp", rec_amp, k);
            step('0, 1'b0, 1'b1);
        end
        check("drain_empty", rec_valid, 0);
        for (int k = 0; k < MS - DEPTH; k++) step('0, 1'b0, 1'b1);

        // sync at sample 5 discards the window holding 0x0FF
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step(13'h0FF, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1);
        step('0, 1'b0, 1'b1);
        step(13'h055, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step('0, 1'b0, 1'b1);
        check("sync_valid", rec_valid, 1);
        check("sync_amp", rec_amp, 13'h055);
        check("sync_idx", rec_idx, 2);
        step('0, 1'b1, 1'b1);
        for (int k = 1; k < MS; k++) step('0, 1'b0, 1'b1);

        // threshold boundary
        thresh = 13'h100;
        clear_wv();
        wv[2] = 13'h0FF;
        run_win(1'b1);
`ifdef TRIG_READER_THRESH_EN
        check("thr_below", rec_valid, 0);
`else
        check("thr_below", rec_valid, 1);
        check("thr_below_amp", rec_amp, 13'h0FF);
`endif
        clear_wv();
        wv[2] = 13'h100;
        run_win(1'b1);
        check("thr_equal", rec_valid, 1);
        check("thr_equal_amp", rec_amp, 13'h100);

        // async reset mid-window with records queued
        clear_wv();
        wv[0] = 13'h007;
        run_win(1'b0);
        wv[0] = 13'h008;
        run_win(1'b0);
        step(13'h009, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check("pre_rst_valid", rec_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", rec_valid, 0);
        check("async_rst_ovf", overflow, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_wv();
        wv[4] = 13'h00A;
        run_win(1'b0);
        check("post_rst_idx", rec_idx, 4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [12:0] d;
            logic        s;
            logic        r;
            d = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(1, 13'h1FFF)) : '0;
            s = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 1) == 1);
            step(d, s, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elink_trig_peak_reader.md
ELINK_TRIG_PEAK_READER -- requirements
Module: elink_trig_peak_reader

Interface
REQ-001 SHALL have parameter MULTISAMPLE, default 8, samples per trigger window (power of two, 2..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, record FIFO depth (power of two, >=2).
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 data_in  input  13  summed trigger word stream, one word per clk; nonzero word marks window peak.
REQ-006 sync  input  1  window alignment strobe; word on this cycle is sample 0.
REQ-007 thresh  input  13  minimum accepted peak amplitude (present only when TRIG_READER_THRESH_EN defined).
REQ-008 rec_valid  output  1  record available (FIFO not empty).
REQ-009 rec_ready  input  1  downstream accepts record; transfer when rec_valid && rec_ready.
REQ-010 rec_amp  output  13  peak amplitude of head record.
REQ-011 rec_idx  output  4  sample index (0..MULTISAMPLE-1) of peak within window.
REQ-012 rec_multi  output  1  more than one nonzero word seen in window.
REQ-013 overflow  output  1  sticky: a record was dropped because FIFO was full.

Function
REQ-014 Sample counter SHALL run 0..MULTISAMPLE-1 and wrap to 0 every cycle after reset, starting at 0 on first cycle after rst_n deasserts.
REQ-015 sync high SHALL force the current word to be sample 0 and counter to 1 next cycle; accumulated partial window SHALL be discarded without a record.
REQ-016 sync high coincident with the word the counter already treats as sample 0 SHALL have no effect beyond normal operation.
REQ-017 Per window, the first nonzero data_in SHALL be latched as amplitude with its sample index; later nonzero words SHALL only set the multi flag.
REQ-018 On the last sample (index MULTISAMPLE-1, itself included in the search), a record SHALL be pushed if a peak was latched (and accepted per REQ-027); window state SHALL clear for the next window in the same edge.
REQ-019 Window with all-zero words SHALL produce no record.
REQ-020 Latency: record pushed at the edge capturing the last sample; rec_valid SHALL be high immediately after that edge if FIFO was empty.
REQ-021 Outputs rec_amp/rec_idx/rec_multi SHALL show FIFO head, stable while rec_valid && !rec_ready.
REQ-022 Push when full and no pop SHALL drop the new record and set overflow; existing contents unchanged.
REQ-023 Simultaneous push and pop when full SHALL succeed with no overflow; simultaneous push and pop when empty SHALL leave one record (the new one) and rec_valid high.
REQ-024 Pop when empty SHALL be ignored.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with occupancy counter width clog2(FIFO_DEPTH)+1.

Reset
REQ-026 rst_n low SHALL asynchronously clear: counter=0, window state, FIFO (empty), rec_valid=0, rec_amp=0, rec_idx=0, rec_multi=0, overflow=0; reset mid-window SHALL discard the partial window and all queued records.

Configuration
REQ-027 With TRIG_READER_THRESH_EN defined, thresh port SHALL exist and a latched peak SHALL be pushed only if amplitude >= thresh (unsigned), below-threshold windows producing no record; without it, thresh port SHALL be absent and every nonzero peak SHALL be pushed.

Verification
REQ-028 Reset, then 8 words 0,0,0,0x123,0,0,0,0 with rec_ready=1 -> one record amp=0x123 idx=3 multi=0, rec_valid high one cycle after sample 7.
REQ-029 Window 0,0x010,0,0,0x020,0,0,0 -> record amp=0x010 idx=1 multi=1; all-zero window -> no record.
REQ-030 rec_ready=0, six windows each with peak 0x001..0x006 -> FIFO holds 0x001..0x004, overflow=1; then rec_ready=1 drains 0x001..0x004 in order.
REQ-031 sync asserted at sample 5 of a window containing peak 0x0FF at idx 2 -> no record for that window; next peak 0x055 two words after sync -> record idx=2.
REQ-032 TRIG_READER_THRESH_EN defined, thresh=0x100: peaks 0x0FF and 0x100 in consecutive windows -> only 0x100 recorded; undefined build -> both recorded.
REQ-033 rst_n pulsed low mid-window with 2 records queued -> rec_valid=0, overflow=0 asynchronously; no record from interrupted window.
